// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial N-bit adder/subtractor, one full-adder cell plus carry FF,
// LSB first, start/done handshake with carry and signed-overflow flags.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra, rb, res;
    logic [CW-1:0]    cnt;
    logic             cy, s, co;

    assign s  = ra[0] ^ rb[0] ^ cy;
    assign co = (ra[0] & rb[0]) | (ra[0] & cy) | (rb[0] & cy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            res      <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // subtraction as a + ~b + 1: invert B and seed the carry
                        ra    <= a;
                        rb    <= sub ? ~b : b;
                        cy    <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    res <= {s, res[WIDTH-1:1]};
                    cy  <= co;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // cy here is the carry into the MSB
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= {s, res[WIDTH-1:1]};
                        c_out    <= co;
                        overflow <= cy ^ co;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: vector table, hand-written handshake/reset sequences, random ops
// and a WIDTH=4 exhaustive sweep against an arithmetic reference.
module tb_serial_addsub;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start8 = 1'b0, sub8 = 1'b0, busy8, done8, co8, ov8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic start4 = 1'b0, sub4 = 1'b0, busy4, done4, co4, ov4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .overflow(ov8)
    );
    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(co4), .overflow(ov4)
    );

    typedef struct {
        logic [7:0] a, b;
        logic       sub;
        logic [7:0] sum;
        logic       co, ov;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", n, got, exp);
        end
    endtask

    // signed/unsigned interpretation of a +/- b, modulo 2^w
    function automatic logic [9:0] model(input int w, input int a, input int b, input bit s);
        int m, sa, sb, r, u;
        bit ov, co;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        r  = s ? sa - sb : sa + sb;
        ov = (r >= m / 2) || (r < -(m / 2));
        co = s ? (a >= b) : (a + b >= m);
        u  = ((s ? a - b : a + b) % m + m) % m;
        return {ov, co, u[7:0]};
    endfunction

    task automatic go(input int w, input logic [7:0] a, input logic [7:0] b, input logic s,
                      output int lat);
        @(negedge clk);
        if (w == 8) begin a8 = a; b8 = b; sub8 = s; start8 = 1'b1; end
        else begin a4 = a[3:0]; b4 = b[3:0]; sub4 = s; start4 = 1'b1; end
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            start4 = 1'b0;
            if (w == 8 ? done8 : done4) lat = k - 1;
        end
    endtask

    task automatic run_check(input string n, input int w, input logic [7:0] a,
                             input logic [7:0] b, input logic s);
        int lat;
        logic [9:0] e;
        e = model(w, int'(a), int'(b), s);
        go(w, a, b, s, lat);
        chk({n, " latency"}, lat, w);
        chk({n, " sum"}, w == 8 ? sum8 : {4'h0, sum4}, e[7:0]);
        chk({n, " c_out"}, w == 8 ? co8 : co4, e[8]);
        chk({n, " overflow"}, w == 8 ? ov8 : ov4, e[9]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        int lat, nd, first;
        tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

        #2;
        chk("reset busy", busy8, 1'b0);
        chk("reset done", done8, 1'b0);
        chk("reset sum", sum8, 8'h00);
        chk("reset c_out", co8, 1'b0);
        chk("reset overflow", ov8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            go(8, tbl[i].a, tbl[i].b, tbl[i].sub, lat);
            chk($sformatf("vec%0d latency", i), lat, 8);
            chk($sformatf("vec%0d sum", i), sum8, tbl[i].sum);
            chk($sformatf("vec%0d c_out", i), co8, tbl[i].co);
            chk($sformatf("vec%0d overflow", i), ov8, tbl[i].ov);
        end

        // start pulses during SHIFT must be ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        nd = 0; first = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) chk("busy during op", busy8, 1'b1);
            if (done8) begin nd++; if (first < 0) first = k - 1; end
            start8 = (k == 3 || k == 5);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        end
        start8 = 1'b0;
        chk("ignored start done count", nd, 1);
        chk("ignored start latency", first, 8);
        chk("ignored start sum", sum8, 8'h30);

        // start held through DONE: second op begins with no idle gap
        @(negedge clk);
        a8 = 8'h21; b8 = 8'h13; sub8 = 1'b1; start8 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (done8) lat = k - 1;
        end
        chk("b2b first latency", lat, 8);
        chk("b2b first sum", sum8, 8'h0E);
        chk("b2b busy in done", busy8, 1'b0);
        a8 = 8'h44; b8 = 8'h45; sub8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b no gap busy", busy8, 1'b1);
        chk("b2b hold sum", sum8, 8'h0E);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (done8) lat = k;
        end
        chk("b2b second latency", lat, 8);
        chk("b2b second sum", sum8, 8'h89);
        chk("b2b second overflow", ov8, 1'b1);

        // asynchronous abort mid-operation
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
        repeat (4) begin @(negedge clk); start8 = 1'b0; end
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy8, 1'b0);
        chk("abort done", done8, 1'b0);
        chk("abort sum", sum8, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (14) begin @(negedge clk); if (done8) nd++; end
        chk("abort no done", nd, 0);

        for (int i = 0; i < 60; i++)
            run_check($sformatf("rand%0d", i), 8, 8'($urandom), 8'($urandom), 1'($urandom));

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run_check($sformatf("w4 a=%0d b=%0d sub=%0d", a, b, s), 4, 8'(a), 8'(b), 1'(s));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
